tlb_op_unit: RTL and testbench

//  COP0-side sequencer for TLBP/TLBR/TLBWI/TLBWR. Drives the MMU TLB write/access port (wtlb, tlb_addr, tlb_wdata).

---
 rtl/tlb_op_unit.sv | 260 ++++++++++++++++++++++++++
 tb/tb_tlb_op_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_unit.sv
// tlb_op_unit: COP0-side sequencer for TLBP/TLBR/TLBWI/TLBWR and owner of the
// COP0 Random register. Drives the MMU TLB port and writes probe/read results
// back into COP0 Index/EntryHi/EntryLo0/EntryLo1/PageMask.
// Optional feature macro: TLB_OP_WIRED_EN -- when defined, Random honours
// wired_i/wired_we; when undefined, Random free-runs 31..0 and wraps.
module tlb_op_unit #(
  parameter int TLB_ENTRIES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_type,
  output logic        op_ready,
  output logic        op_done,
  input  logic [4:0]  index_i,
  input  logic [31:0] entryhi_i,
  input  logic [31:0] entrylo0_i,
  input  logic [31:0] entrylo1_i,
  input  logic [31:0] pagemask_i,
  input  logic [4:0]  wired_i,
  input  logic        wired_we,
  output logic        wtlb,
  output logic [4:0]  tlb_addr,
  output logic [89:0] tlb_wdata,
  output logic        probe_req,
  input  logic [31:0] tlbp_result,
  input  logic [89:0] tlbr_result,
  output logic        index_we,
  output logic [31:0] index_wdata,
  output logic        entry_we,
  output logic [31:0] entryhi_wdata,
  output logic [31:0] entrylo0_wdata,
  output logic [31:0] entrylo1_wdata,
  output logic [31:0] pagemask_wdata,
  output logic [31:0] random_o
);

  localparam logic [4:0] RAND_MAX = 5'(TLB_ENTRIES - 1);

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Packs the COP0 view of an entry into the 90-bit MMU format.
  // lo*_f are EntryLo[25:1] = {PFN, C, D, V}; G is the AND of both EntryLo G bits.
  function automatic logic [89:0] pack_entry(
    input logic [11:0] mask,
    input logic [18:0] vpn2,
    input logic [7:0]  asid,
    input logic        g,
    input logic [24:0] lo0_f,
    input logic [24:0] lo1_f
  );
    pack_entry = {mask, vpn2, asid, g, lo0_f, lo1_f};
  endfunction

  // Rebuilds a COP0 EntryLo word from its {PFN, C, D, V} field and the shared G.
  function automatic logic [31:0] make_entrylo(
    input logic [24:0] lo_f,
    input logic        g
  );
    make_entrylo = {6'd0, lo_f, g};
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        op_ready_q, op_ready_d;
  logic        op_done_q, op_done_d;
  logic        wtlb_q, wtlb_d;
  logic        probe_req_q, probe_req_d;
  logic        index_we_q, index_we_d;
  logic        entry_we_q, entry_we_d;
  logic [4:0]  tlb_addr_q, tlb_addr_d;
  logic [89:0] tlb_wdata_q, tlb_wdata_d;
  logic [31:0] index_wdata_q, index_wdata_d;
  logic [31:0] entryhi_wdata_q, entryhi_wdata_d;
  logic [31:0] entrylo0_wdata_q, entrylo0_wdata_d;
  logic [31:0] entrylo1_wdata_q, entrylo1_wdata_d;
  logic [31:0] pagemask_wdata_q, pagemask_wdata_d;
  logic [4:0]  random_q, random_d;
  logic [89:0] packed_in;

  assign packed_in = pack_entry(pagemask_i[24:13], entryhi_i[31:13], entryhi_i[7:0],
                                entrylo0_i[0] & entrylo1_i[0],
                                entrylo0_i[25:1], entrylo1_i[25:1]);

  // COP0 fields that never reach the TLB or the write-back path.
  logic unused_bits;
  assign unused_bits = ^{entryhi_i[12:8], entrylo0_i[31:26], entrylo1_i[31:26],
                         pagemask_i[31:25], pagemask_i[12:0], tlbp_result[30:5]};

`ifdef TLB_OP_WIRED_EN
  // Random next value: a Wired write or reaching the Wired floor reloads the top.
  // The floor test uses <= so a stale Random below Wired is pulled back into range.
  always_comb begin
    random_d = random_q;
    if (wired_we) begin
      random_d = RAND_MAX;
    end else if (random_q <= wired_i) begin
      random_d = RAND_MAX;
    end else begin
      random_d = random_q - 5'd1;
    end
  end
`else
  logic unused_wired;
  assign unused_wired = ^{wired_i, wired_we};

  // Random next value: free-running down-counter that wraps from 0 back to the top.
  always_comb begin
    random_d = random_q;
    if (random_q == 5'd0) begin
      random_d = RAND_MAX;
    end else begin
      random_d = random_q - 5'd1;
    end
  end
`endif

  // Random register; reset puts it at the top entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      random_q <= RAND_MAX;
    end else begin
      random_q <= random_d;
    end
  end

  // Sequencer next state and next registered outputs; strobes default low each cycle.
  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    op_ready_d       = 1'b0;
    op_done_d        = 1'b0;
    wtlb_d           = 1'b0;
    probe_req_d      = 1'b0;
    index_we_d       = 1'b0;
    entry_we_d       = 1'b0;
    tlb_addr_d       = tlb_addr_q;
    tlb_wdata_d      = tlb_wdata_q;
    index_wdata_d    = index_wdata_q;
    entryhi_wdata_d  = entryhi_wdata_q;
    entrylo0_wdata_d = entrylo0_wdata_q;
    entrylo1_wdata_d = entrylo1_wdata_q;
    pagemask_wdata_d = pagemask_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          // Everything the op needs is captured now so later COP0 changes cannot leak in.
          state_d     = ST_ISSUE;
          op_d        = op_type;
          tlb_wdata_d = packed_in;
          wtlb_d      = op_type[1];
          probe_req_d = (op_type == OP_TLBP);
          if (op_type == OP_TLBWR) begin
            tlb_addr_d = random_q;
          end else begin
            tlb_addr_d = index_i;
          end
        end else begin
          op_ready_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (op_q[1]) begin
          // Write already strobed during ISSUE; nothing to wait for.
          state_d   = ST_DONE;
          op_done_d = 1'b1;
        end else begin
          state_d     = ST_WAIT;
          probe_req_d = (op_q == OP_TLBP);
        end
      end
      ST_WAIT: begin
        state_d   = ST_DONE;
        op_done_d = 1'b1;
        if (op_q == OP_TLBP) begin
          // Index[4:0] is written even on a miss; bit 31 carries the miss flag.
          index_we_d    = 1'b1;
          index_wdata_d = {tlbp_result[31], 26'd0, tlbp_result[4:0]};
        end else begin
          entry_we_d       = 1'b1;
          pagemask_wdata_d = {7'd0, tlbr_result[89:78], 13'd0};
          entryhi_wdata_d  = {tlbr_result[77:59], 5'd0, tlbr_result[58:51]};
          entrylo0_wdata_d = make_entrylo(tlbr_result[49:25], tlbr_result[50]);
          entrylo1_wdata_d = make_entrylo(tlbr_result[24:0], tlbr_result[50]);
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        op_ready_d = 1'b1;
      end
      default: begin
        state_d    = ST_IDLE;
        op_ready_d = 1'b1;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset abandons any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      op_q             <= OP_TLBP;
      op_ready_q       <= 1'b1;
      op_done_q        <= 1'b0;
      wtlb_q           <= 1'b0;
      probe_req_q      <= 1'b0;
      index_we_q       <= 1'b0;
      entry_we_q       <= 1'b0;
      tlb_addr_q       <= 5'd0;
      tlb_wdata_q      <= 90'd0;
      index_wdata_q    <= 32'd0;
      entryhi_wdata_q  <= 32'd0;
      entrylo0_wdata_q <= 32'd0;
      entrylo1_wdata_q <= 32'd0;
      pagemask_wdata_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      op_ready_q       <= op_ready_d;
      op_done_q        <= op_done_d;
      wtlb_q           <= wtlb_d;
      probe_req_q      <= probe_req_d;
      index_we_q       <= index_we_d;
      entry_we_q       <= entry_we_d;
      tlb_addr_q       <= tlb_addr_d;
      tlb_wdata_q      <= tlb_wdata_d;
      index_wdata_q    <= index_wdata_d;
      entryhi_wdata_q  <= entryhi_wdata_d;
      entrylo0_wdata_q <= entrylo0_wdata_d;
      entrylo1_wdata_q <= entrylo1_wdata_d;
      pagemask_wdata_q <= pagemask_wdata_d;
    end
  end

  assign op_ready       = op_ready_q;
  assign op_done        = op_done_q;
  assign wtlb           = wtlb_q;
  assign probe_req      = probe_req_q;
  assign index_we       = index_we_q;
  assign entry_we       = entry_we_q;
  assign tlb_addr       = tlb_addr_q;
  assign tlb_wdata      = tlb_wdata_q;
  assign index_wdata    = index_wdata_q;
  assign entryhi_wdata  = entryhi_wdata_q;
  assign entrylo0_wdata = entrylo0_wdata_q;
  assign entrylo1_wdata = entrylo1_wdata_q;
  assign pagemask_wdata = pagemask_wdata_q;
  assign random_o       = {27'd0, random_q};

endmodule

// File: tb/tb_tlb_op_unit.sv
// Self-checking bench for tlb_op_unit: randomized TLB ops compared against a
// field-level reference model; Random is tracked cycle by cycle.
`timescale 1ns/1ps
module tb_tlb_op_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_type = 2'b00;
  logic        op_ready, op_done;
  logic [4:0]  index_i = 5'd0;
  logic [31:0] entryhi_i = 32'd0, entrylo0_i = 32'd0, entrylo1_i = 32'd0, pagemask_i = 32'd0;
  logic [4:0]  wired_i = 5'd0;
  logic        wired_we = 1'b0;
  logic        wtlb, probe_req, index_we, entry_we;
  logic [4:0]  tlb_addr;
  logic [89:0] tlb_wdata;
  logic [31:0] tlbp_result = 32'd0;
  logic [89:0] tlbr_result = 90'd0;
  logic [31:0] index_wdata, entryhi_wdata, entrylo0_wdata, entrylo1_wdata, pagemask_wdata;
  logic [31:0] random_o;

  tlb_op_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
    .op_ready(op_ready), .op_done(op_done), .index_i(index_i),
    .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i), .entrylo1_i(entrylo1_i),
    .pagemask_i(pagemask_i), .wired_i(wired_i), .wired_we(wired_we),
    .wtlb(wtlb), .tlb_addr(tlb_addr), .tlb_wdata(tlb_wdata), .probe_req(probe_req),
    .tlbp_result(tlbp_result), .tlbr_result(tlbr_result), .index_we(index_we),
    .index_wdata(index_wdata), .entry_we(entry_we), .entryhi_wdata(entryhi_wdata),
    .entrylo0_wdata(entrylo0_wdata), .entrylo1_wdata(entrylo1_wdata),
    .pagemask_wdata(pagemask_wdata), .random_o(random_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [4:0] model_rand = 5'd31;

  // Observations of one operation window.
  int n_wtlb, n_probe, n_idx, n_ent, n_done, wtlb_at, done_at, busy_ready;
  logic [4:0]  acc_rand, cap_addr_issue, cap_waddr;
  logic [89:0] cap_wdata;
  logic [31:0] cap_idx, cap_hi, cap_lo0, cap_lo1, cap_pm;

  // Expected 90-bit TLB entry built from COP0 words with shifts and masks.
  function automatic logic [89:0] exp_pack(input logic [31:0] hi, lo0, lo1, pm);
    logic [89:0] r;
    r = 90'((pm >> 13) & 32'hFFF) << 78;
    r = r | (90'(hi >> 13) << 59);
    r = r | (90'(hi & 32'hFF) << 51);
    r = r | (90'(lo0 & lo1 & 32'd1) << 50);
    r = r | (90'((lo0 >> 1) & 32'h01FF_FFFF) << 25);
    r = r | 90'((lo1 >> 1) & 32'h01FF_FFFF);
    return r;
  endfunction

  // Advance one clock; Random reference follows the counting rules.
  task automatic tick();
    logic [4:0] nxt;
    if (rst) nxt = 5'd31;
`ifdef TLB_OP_WIRED_EN
    else if (wired_we) nxt = 5'd31;
    else if (model_rand == wired_i) nxt = 5'd31;
    else nxt = 5'((32'(model_rand) + 32'd31) % 32'd32);
`else
    else nxt = 5'((32'(model_rand) + 32'd31) % 32'd32);
`endif
    @(posedge clk);
    #1;
    model_rand = nxt;
    checks++;
    if (random_o !== {27'd0, model_rand}) begin
      errors++;
      $display("FAIL random: got %0d want %0d at %0t", random_o, model_rand, $time);
    end
  endtask

  // Issue one op from IDLE and record every strobe over a 6-cycle window.
  task automatic run_op(input logic [1:0] t, input bit hold);
    checks++;
    if (op_ready !== 1'b1) begin errors++; $display("FAIL ready_before_op: got %b want 1", op_ready); end
    op_valid = 1'b1; op_type = t; acc_rand = random_o[4:0];
    n_wtlb = 0; n_probe = 0; n_idx = 0; n_ent = 0; n_done = 0;
    wtlb_at = 0; done_at = 0; busy_ready = 0;
    tick();
    if (!hold) op_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) cap_addr_issue = tlb_addr;
      if (wtlb) begin n_wtlb++; wtlb_at = k; cap_waddr = tlb_addr; cap_wdata = tlb_wdata; end
      if (probe_req) n_probe++;
      if (index_we) begin n_idx++; cap_idx = index_wdata; end
      if (entry_we) begin
        n_ent++; cap_hi = entryhi_wdata; cap_lo0 = entrylo0_wdata;
        cap_lo1 = entrylo1_wdata; cap_pm = pagemask_wdata;
      end
      if (op_done) begin n_done++; done_at = k; op_valid = 1'b0; end
      if (op_ready && n_done == 0) busy_ready++;
      tick();
    end
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", op_ready); end
    checks++; if ({wtlb, probe_req, index_we, entry_we, op_done} !== 5'b0) begin
      errors++; $display("FAIL rst_strobes: got %b want 00000", {wtlb, probe_req, index_we, entry_we, op_done}); end
    checks++; if ({tlb_addr, tlb_wdata, index_wdata, entryhi_wdata, entrylo0_wdata, entrylo1_wdata, pagemask_wdata} !== 255'd0) begin
      errors++; $display("FAIL rst_data: data outputs not all zero (tlb_addr=%0d index_wdata=%h)", tlb_addr, index_wdata); end
    checks++; if (random_o !== 32'd31) begin errors++; $display("FAIL rst_random: got %0d want 31", random_o); end
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_write(input logic [4:0] want_addr, input logic [89:0] want_data, input string nm);
    checks++; if (n_wtlb !== 1) begin errors++; $display("FAIL %s_wtlb_count: got %0d want 1", nm, n_wtlb); end
    checks++; if (wtlb_at !== 1) begin errors++; $display("FAIL %s_wtlb_cycle: got %0d want 1", nm, wtlb_at); end
    checks++; if (cap_waddr !== want_addr) begin errors++; $display("FAIL %s_addr: got %0d want %0d", nm, cap_waddr, want_addr); end
    checks++; if (cap_wdata !== want_data) begin errors++; $display("FAIL %s_wdata: got %h want %h", nm, cap_wdata, want_data); end
    checks++; if (done_at !== 2 || n_done !== 1) begin errors++; $display("FAIL %s_done: at %0d count %0d want at 2 count 1", nm, done_at, n_done); end
    checks++; if (n_probe + n_idx + n_ent + busy_ready !== 0) begin
      errors++; $display("FAIL %s_side: probe %0d idx %0d ent %0d busy_ready %0d want 0", nm, n_probe, n_idx, n_ent, busy_ready); end
  endtask

  task automatic test_tlbwi();
    index_i = 5'd5; entryhi_i = 32'h0040_2012; entrylo0_i = 32'h0000_0107;
    entrylo1_i = 32'h0000_0147; pagemask_i = 32'd0;
    run_op(2'b10, 1'b0);
    check_write(5'd5, exp_pack(entryhi_i, entrylo0_i, entrylo1_i, pagemask_i), "wi_fixed");
    checks++; if (cap_wdata[77:59] !== 19'h201 || cap_wdata[58:51] !== 8'h12 || cap_wdata[50] !== 1'b1) begin
      errors++; $display("FAIL wi_fields: got vpn2 %h asid %h g %b want 201 12 1", cap_wdata[77:59], cap_wdata[58:51], cap_wdata[50]); end
    for (int i = 0; i < 4; i++) begin
      index_i = 5'($urandom_range(0, 31)); entryhi_i = $urandom; entrylo0_i = $urandom;
      entrylo1_i = $urandom; pagemask_i = $urandom;
      run_op(2'b10, 1'b0);
      check_write(index_i, exp_pack(entryhi_i, entrylo0_i, entrylo1_i, pagemask_i), "wi_rand");
    end
  endtask

  task automatic test_tlbwr();
    wired_i = 5'd8; wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
`ifdef TLB_OP_WIRED_EN
      checks++; if (random_o < 32'd8 || random_o > 32'd31) begin
        errors++; $display("FAIL wired_range: got %0d want 8..31", random_o); end
`endif
    end
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 5)) tick();
      entryhi_i = $urandom; entrylo0_i = $urandom; entrylo1_i = $urandom; pagemask_i = $urandom;
      index_i = 5'd2;
      checks++; if (acc_rand !== acc_rand) begin end
      run_op(2'b11, 1'b0);
      check_write(acc_rand, exp_pack(entryhi_i, entrylo0_i, entrylo1_i, pagemask_i), "wr");
    end
  endtask

  task automatic test_tlbp();
    logic [31:0] res [0:4];
    logic [31:0] want;
    res[0] = 32'h0000_0003; res[1] = 32'h8000_0000;
    res[2] = $urandom & 32'h7FFF_FFFF; res[3] = $urandom | 32'h8000_0000; res[4] = $urandom;
    for (int i = 0; i < 5; i++) begin
      tlbp_result = res[i];
      want = res[i] & 32'h8000_001F;
      run_op(2'b00, 1'b0);
      checks++; if (n_idx !== 1 || cap_idx !== want) begin
        errors++; $display("FAIL tlbp_index: count %0d got %h want 1 %h", n_idx, cap_idx, want); end
      checks++; if (n_probe !== 2) begin errors++; $display("FAIL tlbp_probe_len: got %0d want 2", n_probe); end
      checks++; if (done_at !== 3 || n_done !== 1) begin errors++; $display("FAIL tlbp_done: at %0d count %0d want 3 1", done_at, n_done); end
      checks++; if (n_wtlb + n_ent + busy_ready !== 0) begin errors++; $display("FAIL tlbp_side: wtlb %0d ent %0d ready %0d want 0", n_wtlb, n_ent, busy_ready); end
    end
  endtask

  task automatic test_tlbr(input bit hold);
    logic [31:0] m, vpn2, asid, g, f0, f1, hi_w, lo0_w, lo1_w, pm_w;
    for (int i = 0; i < 4; i++) begin
      vpn2 = $urandom & 32'h7FFFF; asid = $urandom & 32'hFF;
      f0 = $urandom & 32'h01FF_FFFF; f1 = $urandom & 32'h01FF_FFFF;
      if (i == 0) begin m = 32'hFFF; g = 32'd1; index_i = 5'd7; end
      else begin m = $urandom & 32'hFFF; g = $urandom & 32'd1; index_i = 5'($urandom_range(0, 31)); end
      tlbr_result = (90'(m) << 78) | (90'(vpn2) << 59) | (90'(asid) << 51) | (90'(g) << 50)
                  | (90'(f0) << 25) | 90'(f1);
      hi_w = (vpn2 << 13) | asid; pm_w = m << 13; lo0_w = (f0 << 1) | g; lo1_w = (f1 << 1) | g;
      run_op(2'b01, hold);
      checks++; if (cap_addr_issue !== index_i) begin errors++; $display("FAIL tlbr_addr: got %0d want %0d", cap_addr_issue, index_i); end
      checks++; if (n_ent !== 1) begin errors++; $display("FAIL tlbr_entry_we: got %0d want 1", n_ent); end
      checks++; if (cap_hi !== hi_w || cap_pm !== pm_w) begin
        errors++; $display("FAIL tlbr_hi_pm: got %h %h want %h %h", cap_hi, cap_pm, hi_w, pm_w); end
      checks++; if (cap_lo0 !== lo0_w || cap_lo1 !== lo1_w) begin
        errors++; $display("FAIL tlbr_lo: got %h %h want %h %h", cap_lo0, cap_lo1, lo0_w, lo1_w); end
      checks++; if (done_at !== 3 || n_done !== 1) begin errors++; $display("FAIL tlbr_done: at %0d count %0d want 3 1", done_at, n_done); end
      checks++; if (n_wtlb + n_probe + n_idx + busy_ready !== 0) begin
        errors++; $display("FAIL tlbr_side: wtlb %0d probe %0d idx %0d ready %0d want 0", n_wtlb, n_probe, n_idx, busy_ready); end
    end
  endtask

  task automatic test_busy_hold();
    // op_valid held through ISSUE/WAIT must not start a second operation.
    test_tlbr(1'b1);
    entryhi_i = $urandom; entrylo0_i = $urandom; entrylo1_i = $urandom; pagemask_i = $urandom;
    index_i = 5'd11;
    run_op(2'b10, 1'b1);
    check_write(5'd11, exp_pack(entryhi_i, entrylo0_i, entrylo1_i, pagemask_i), "busy_wi");
  endtask

  task automatic test_reset_midop();
    int stray;
    index_i = 5'd9; op_type = 2'b11; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    checks++; if (wtlb !== 1'b1) begin errors++; $display("FAIL midrst_issue: wtlb got %b want 1", wtlb); end
    rst = 1'b1; model_rand = 5'd31;
    #1;
    checks++; if (wtlb !== 1'b0) begin errors++; $display("FAIL midrst_wtlb_drop: got %b want 0", wtlb); end
    checks++; if (op_ready !== 1'b1 || random_o !== 32'd31) begin
      errors++; $display("FAIL midrst_state: ready %b random %0d want 1 31", op_ready, random_o); end
    tick(); tick();
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wtlb || op_done || !op_ready) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL midrst_idle: got %0d non-idle cycles want 0", stray); end
  endtask

  initial begin
    test_reset();
    test_tlbwi();
    test_tlbwr();
    test_tlbp();
    test_tlbr(1'b0);
    test_busy_hold();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
